// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: programmable serial pattern detector with match counting and match limit.
// Optional first-match position capture is enabled by defining PSC_FIRST_POS_EN.
module pattern_scan_ctrl #(
    parameter int MAXLEN = 8,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_limit,
    input  logic              start,
    input  logic              stop,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  first_pos,
    output logic              first_vld
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [MAXLEN-1:0]   pat_q;
    logic [LEN_W-1:0]    len_q;
    logic                ovl_q;
    logic [CNT_W-1:0]    limit_q;
    logic [MAXLEN-1:0]   hist;
    logic [LEN_W-1:0]    fill;

    logic                len_ok;
    logic                accept;
    logic                fill_full;
    logic                hit;
    logic                arm;
    logic                err;
    logic [MAXLEN-1:0]   hist_new;
    logic [MAXLEN-1:0]   mask;
    logic [LEN_W:0]      fill_inc;
    logic [CNT_W-1:0]    cnt_next;

    assign bit_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // Hit evaluation uses the history including the bit being accepted this cycle.
    always_comb begin
        len_ok    = (len_q != '0) && (int'(len_q) <= MAXLEN);
        accept    = bit_valid && bit_ready;
        hist_new  = (hist << 1) | MAXLEN'(bit_in);
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        fill_inc  = {1'b0, fill} + (LEN_W+1)'(1);
        fill_full = (fill_inc >= {1'b0, len_q});
        hit       = accept && fill_full && ((hist_new & mask) == (pat_q & mask));
        cnt_next  = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
        arm       = start && !stop && (((state == IDLE) && len_ok) || (state == DONE));
        err       = start && !stop && (state == IDLE) && !len_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat_q     <= MAXLEN'(4'b0110);
            len_q     <= LEN_W'(4);
            ovl_q     <= 1'b1;
            limit_q   <= '0;
            hist      <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= err;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q   <= cfg_pattern;
                        len_q   <= cfg_len;
                        ovl_q   <= cfg_overlap;
                        limit_q <= cfg_limit;
                    end
                    if (arm) state <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        hist <= hist_new;
                        if (hit && !ovl_q)
                            fill <= '0;
                        else if (fill_full)
                            fill <= len_q;
                        else
                            fill <= fill_inc[LEN_W-1:0];
                        if (hit) begin
                            match     <= 1'b1;
                            match_cnt <= cnt_next;
                        end
                    end
                    // A stop in the same cycle as the limit-reaching hit takes precedence.
                    if (stop)
                        state <= IDLE;
                    else if (hit && (limit_q != '0) && (cnt_next == limit_q))
                        state <= DONE;
                end
                DONE: begin
                    if (stop)
                        state <= IDLE;
                    else if (arm)
                        state <= RUN;
                end
                default: state <= IDLE;
            endcase
            if (arm) begin
                hist      <= '0;
                fill      <= '0;
                match_cnt <= '0;
            end
        end
    end

`ifdef PSC_FIRST_POS_EN
    logic [CNT_W-1:0] bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= '0;
            first_pos <= '0;
            first_vld <= 1'b0;
        end else if (arm) begin
            bit_idx   <= '0;
            first_pos <= '0;
            first_vld <= 1'b0;
        end else if (accept) begin
            if (bit_idx != '1) bit_idx <= bit_idx + CNT_W'(1);
            if (hit && !first_vld) begin
                first_pos <= bit_idx;
                first_vld <= 1'b1;
            end
        end
    end
`else
    assign first_pos = '0;
    assign first_vld = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed self-checking bench for pattern_scan_ctrl.
// Define PSC_FIRST_POS_EN for both files to exercise first-match capture.
module tb_pattern_scan_ctrl;

    localparam int MAXLEN = 8;
    localparam int LEN_W  = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_overlap;
    logic [CNT_W-1:0]  cfg_limit;
    logic              start;
    logic              stop;
    logic              bit_valid;
    logic              bit_in;
    logic              bit_ready;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [CNT_W-1:0]  first_pos;
    logic              first_vld;

    int n_cmp = 0;
    int n_bad = 0;

    pattern_scan_ctrl #(.MAXLEN(MAXLEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
        .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .match(match), .match_cnt(match_cnt),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .first_pos(first_pos), .first_vld(first_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic write_cfg(input logic [MAXLEN-1:0] p, input logic [LEN_W-1:0] l,
                             input logic o, input logic [CNT_W-1:0] lim);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_limit   = lim;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (match !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_match: got %b want 0", match); end
        n_cmp++; if (match_cnt !== '0) begin n_bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", match_cnt); end
        n_cmp++; if ({busy, done, bit_ready, cfg_err} !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy, done, bit_ready, cfg_err}); end
        n_cmp++; if ({first_vld, first_pos} !== '0) begin n_bad++; $display("[TB] FAIL reset_first: got %b/%0d want 0/0", first_vld, first_pos); end
    endtask

    // Streams 0110110 into the default configuration; matches after bits 4 and 7.
    task automatic test_defaults(input string tag);
        logic [6:0] seq;
        logic [6:0] exp;
        seq = 7'b0110110;
        exp = 7'b0001001;
        pulse_start();
        n_cmp++; if ({busy, bit_ready} !== 2'b11) begin n_bad++; $display("[TB] FAIL %s_armed: got %b want 11", tag, {busy, bit_ready}); end
        for (int i = 0; i < 7; i++) begin
            send_bit(seq[6-i]);
            n_cmp++; if (match !== exp[6-i]) begin n_bad++; $display("[TB] FAIL %s_match_bit%0d: got %b want %b", tag, i+1, match, exp[6-i]); end
        end
        n_cmp++; if (match_cnt !== 16'd2) begin n_bad++; $display("[TB] FAIL %s_cnt: got %0d want 2", tag, match_cnt); end
`ifdef PSC_FIRST_POS_EN
        n_cmp++; if ({first_vld, first_pos} !== {1'b1, 16'd3}) begin n_bad++; $display("[TB] FAIL %s_first: got %b/%0d want 1/3", tag, first_vld, first_pos); end
`else
        n_cmp++; if ({first_vld, first_pos} !== '0) begin n_bad++; $display("[TB] FAIL %s_first: got %b/%0d want 0/0", tag, first_vld, first_pos); end
`endif
        pulse_stop();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL %s_stop_busy: got %b want 0", tag, busy); end
        tick();
        n_cmp++; if (match_cnt !== 16'd2) begin n_bad++; $display("[TB] FAIL %s_cnt_held: got %0d want 2", tag, match_cnt); end
    endtask

    task automatic test_no_overlap();
        logic [6:0] seq;
        logic [6:0] exp;
        seq = 7'b0110110;
        exp = 7'b0001000;
        write_cfg(8'b0000_0110, 4'd4, 1'b0, 16'd0);
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            send_bit(seq[6-i]);
            n_cmp++; if (match !== exp[6-i]) begin n_bad++; $display("[TB] FAIL noovl_match_bit%0d: got %b want %b", i+1, match, exp[6-i]); end
        end
        n_cmp++; if (match_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL noovl_cnt: got %0d want 1", match_cnt); end
        pulse_stop();
    endtask

    task automatic test_limit();
        write_cfg(8'b0000_0001, 4'd1, 1'b1, 16'd3);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            n_cmp++; if (match !== 1'b1) begin n_bad++; $display("[TB] FAIL limit_match_bit%0d: got %b want 1", i+1, match); end
        end
        n_cmp++; if ({done, busy, bit_ready} !== 3'b100) begin n_bad++; $display("[TB] FAIL limit_done: got %b want 100", {done, busy, bit_ready}); end
        n_cmp++; if (match_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL limit_cnt: got %0d want 3", match_cnt); end
        send_bit(1'b1);
        n_cmp++; if ({match, done} !== 2'b01) begin n_bad++; $display("[TB] FAIL limit_4th_bit: got match/done %b want 01", {match, done}); end
        n_cmp++; if (match_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL limit_cnt_after: got %0d want 3", match_cnt); end
        pulse_start();
        n_cmp++; if ({busy, done, match_cnt} !== {2'b10, 16'd0}) begin n_bad++; $display("[TB] FAIL limit_rearm: got %b%b/%0d want 10/0", busy, done, match_cnt); end
        pulse_stop();
    endtask

    task automatic test_cfg_rules();
        logic [7:0] seq;
        logic [7:0] exp;
        seq = 8'b0110_1111;
        exp = 8'b0001_0000;
        write_cfg(8'b0000_0110, 4'd0, 1'b1, 16'd0);
        pulse_start();
        n_cmp++; if ({cfg_err, busy} !== 2'b10) begin n_bad++; $display("[TB] FAIL cfgerr_pulse: got %b want 10", {cfg_err, busy}); end
        tick();
        n_cmp++; if ({cfg_err, busy} !== 2'b00) begin n_bad++; $display("[TB] FAIL cfgerr_clear: got %b want 00", {cfg_err, busy}); end
        write_cfg(8'b0000_0110, 4'd4, 1'b1, 16'd0);
        pulse_start();
        write_cfg(8'b0000_1111, 4'd4, 1'b1, 16'd0);
        for (int i = 0; i < 8; i++) begin
            send_bit(seq[7-i]);
            n_cmp++; if (match !== exp[7-i]) begin n_bad++; $display("[TB] FAIL cfgrun_match_bit%0d: got %b want %b", i+1, match, exp[7-i]); end
        end
        pulse_stop();
    endtask

    task automatic test_stop_with_bit();
        pulse_start();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        stop = 1'b1;
        send_bit(1'b0);
        stop = 1'b0;
        n_cmp++; if ({match, busy, bit_ready, done} !== 4'b1000) begin n_bad++; $display("[TB] FAIL stopbit_flags: got %b want 1000", {match, busy, bit_ready, done}); end
        n_cmp++; if (match_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL stopbit_cnt: got %0d want 1", match_cnt); end
    endtask

    task automatic test_limit_and_stop();
        write_cfg(8'b0000_0001, 4'd1, 1'b1, 16'd1);
        pulse_start();
        stop = 1'b1;
        send_bit(1'b1);
        stop = 1'b0;
        n_cmp++; if ({match, done, busy} !== 3'b100) begin n_bad++; $display("[TB] FAIL limstop_flags: got %b want 100", {match, done, busy}); end
    endtask

    task automatic test_reset_mid_run();
        write_cfg(8'b0000_0001, 4'd1, 1'b1, 16'd0);
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        n_cmp++; if (match_cnt !== 16'd5) begin n_bad++; $display("[TB] FAIL midrst_cnt_before: got %0d want 5", match_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({match_cnt, busy, done, match} !== '0) begin n_bad++; $display("[TB] FAIL midrst_async: got cnt %0d flags %b%b%b want 0", match_cnt, busy, done, match); end
        @(negedge clk);
        rst_n = 1'b1;
        test_defaults("postrst");
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_limit = '0; start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_defaults("dflt");
        test_no_overlap();
        test_limit();
        test_cfg_rules();
        test_stop_with_bit();
        test_limit_and_stop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
